uart_receiver: RTL and testbench

//  Serial-to-parallel UART receiver: the far end of uart_transmitter's TxD line.

---
 rtl/uart_receiver.sv | 153 +++++++++++++++
 tb/tb_uart_receiver.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// UART receiver: 1 start, 8 data LSB-first, even parity, 1 stop; 16x oversampled.
// Latency: result pulses ~10.6 bit periods after the start edge, plus 2 clk of input sync.
// No backpressure: each frame yields a 1-clk VALID/PERROR/FERROR pulse; Rx_DATA holds until the next frame ends.
module uart_receiver #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       RxD,
  input  logic [2:0] baud_select,
  input  logic       Rx_EN,
  output logic [7:0] Rx_DATA,
  output logic       Rx_VALID,
  output logic       Rx_PERROR,
  output logic       Rx_FERROR
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);

  // Last divider count (DIV-1) for a rate code, DIV rounded to nearest.
  function automatic logic [13:0] div_last(input logic [2:0] code);
    int baud;
    case (code)
      3'd0: baud = 300;
      3'd1: baud = 1200;
      3'd2: baud = 4800;
      3'd3: baud = 9600;
      3'd4: baud = 19200;
      3'd5: baud = 38400;
      3'd6: baud = 57600;
      3'd7: baud = 115200;
    endcase
    return 14'((CLK_FREQ + (OVERSAMPLE * baud) / 2) / (OVERSAMPLE * baud) - 1);
  endfunction

  logic       rxd_meta, rxd_s, rxd_prev;
  state_t     state;
  logic [2:0] baud_lat;
  logic [13:0] div_cnt;
  logic [13:0] div_max;
  logic [3:0] tick_cnt;
  logic [2:0] bit_cnt;
  logic [7:0] shift;
  logic       s7, s8, par_bit;
  logic       tick, maj, par_err, stop_err;

  assign div_max  = div_last(baud_lat);
  assign tick     = (div_cnt == div_max);
  // Samples from ticks 7 and 8 are held; the tick-9 sample is the live rxd_s.
  assign maj      = (s7 & s8) | (s7 & rxd_s) | (s8 & rxd_s);
  assign par_err  = par_bit ^ (^shift);
  assign stop_err = !maj;

  // Two-flop synchronizer for the async line, plus a delayed copy for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      rxd_meta <= 1'b1;
      rxd_s    <= 1'b1;
      rxd_prev <= 1'b1;
    end else begin
      rxd_meta <= RxD;
      rxd_s    <= rxd_meta;
      rxd_prev <= rxd_s;
    end
  end

  // Frame FSM with its oversampling tick divider and registered result pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      baud_lat  <= 3'd0;
      div_cnt   <= 14'd0;
      tick_cnt  <= 4'd0;
      bit_cnt   <= 3'd0;
      shift     <= 8'h00;
      s7        <= 1'b1;
      s8        <= 1'b1;
      par_bit   <= 1'b0;
      Rx_DATA   <= 8'h00;
      Rx_VALID  <= 1'b0;
      Rx_PERROR <= 1'b0;
      Rx_FERROR <= 1'b0;
    end else begin
      Rx_VALID  <= 1'b0;
      Rx_PERROR <= 1'b0;
      Rx_FERROR <= 1'b0;

      if (state != IDLE) begin
        if (tick) begin
          div_cnt  <= 14'd0;
          tick_cnt <= tick_cnt + 4'd1;
          if (tick_cnt == 4'd7) s7 <= rxd_s;
          if (tick_cnt == 4'd8) s8 <= rxd_s;
        end else begin
          div_cnt <= div_cnt + 14'd1;
        end
      end

      if (state != IDLE && !Rx_EN) begin
        // Disabling mid-frame drops the frame silently.
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (Rx_EN && rxd_prev && !rxd_s) begin
              state    <= START;
              baud_lat <= baud_select;
              div_cnt  <= 14'd0;
              tick_cnt <= 4'd0;
              bit_cnt  <= 3'd0;
            end
          end
          START: begin
            if (tick) begin
              if (tick_cnt == 4'd7 && rxd_s) state <= IDLE;
              else if (tick_cnt == LAST_TICK) state <= DATA;
            end
          end
          DATA: begin
            if (tick) begin
              if (tick_cnt == 4'd9) shift <= {maj, shift[7:1]};
              if (tick_cnt == LAST_TICK) begin
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) state <= PARITY;
              end
            end
          end
          PARITY: begin
            if (tick) begin
              if (tick_cnt == 4'd9) par_bit <= maj;
              if (tick_cnt == LAST_TICK) state <= STOP;
            end
          end
          STOP: begin
            // Report at mid-stop so the next start edge is caught back-to-back.
            if (tick && tick_cnt == 4'd9) begin
              Rx_DATA   <= shift;
              Rx_PERROR <= par_err;
              Rx_FERROR <= stop_err;
              Rx_VALID  <= !par_err && !stop_err;
              state     <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
module tb_uart_receiver;

  logic       clk = 1'b0;
  logic       reset;
  logic       RxD;
  logic [2:0] baud_select;
  logic       Rx_EN;
  logic [7:0] Rx_DATA;
  logic       Rx_VALID, Rx_PERROR, Rx_FERROR;

  always #10 clk = ~clk;

  uart_receiver #(.CLK_FREQ(50_000_000), .OVERSAMPLE(16)) dut (
    .clk(clk),
    .reset(reset),
    .RxD(RxD),
    .baud_select(baud_select),
    .Rx_EN(Rx_EN),
    .Rx_DATA(Rx_DATA),
    .Rx_VALID(Rx_VALID),
    .Rx_PERROR(Rx_PERROR),
    .Rx_FERROR(Rx_FERROR)
  );

  typedef struct {
    logic [7:0] d;
    logic       par;
    logic       stop;
    logic [2:0] baud;
    logic       ev, ep, ef;
  } vec_t;

  typedef struct {
    logic [7:0] d;
    logic       v, p, f;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] last_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Divider values from the rate table, independent of the DUT.
  function automatic int div_for(input logic [2:0] b);
    case (b)
      3'd0: return 10417;
      3'd1: return 2604;
      3'd2: return 651;
      3'd3: return 326;
      3'd4: return 163;
      3'd5: return 81;
      3'd6: return 54;
      default: return 27;
    endcase
  endfunction

  // Advance n clocks, leaving the bench 1 ns after a rising edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic v, input int clks);
    RxD = v;
    tick(clks);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop, input logic [2:0] baud);
    int bclk;
    bclk = div_for(baud) * 16;
    baud_select = baud;
    drive_bit(1'b0, bclk);
    for (int i = 0; i < 8; i++) drive_bit(d[i], bclk);
    drive_bit(par, bclk);
    drive_bit(stop, bclk);
    if (!stop) begin
      // Hold the line low well past the frame, then let it idle high.
      drive_bit(1'b0, 2 * bclk);
      drive_bit(1'b1, bclk);
    end
  endtask

  task automatic expect_frame(input string name, input logic [7:0] d, input logic v,
                              input logic p, input logic f, input logic par, input logic stop,
                              input logic [2:0] baud);
    sb.push_back('{d: d, v: v, p: p, f: f});
    send_frame(d, par, stop, baud);
    check({name, "_pulse_seen"}, sb.size(), 0);
    if (sb.size() != 0) sb.delete();
    check({name, "_data_held"}, Rx_DATA, d);
    last_data = d;
  endtask

  // Abort frame 0xA5 during bit 4, either by disabling or by resetting.
  task automatic abort_frame(input bit use_reset);
    logic [7:0] d;
    int bclk;
    d = 8'hA5;
    bclk = div_for(3'd7) * 16;
    baud_select = 3'd7;
    drive_bit(1'b0, bclk);
    for (int i = 0; i < 4; i++) drive_bit(d[i], bclk);
    drive_bit(d[4], bclk / 2);
    if (use_reset) reset = 1'b1;
    else Rx_EN = 1'b0;
    tick(1);
    if (use_reset) begin
      check("reset_mid_data", Rx_DATA, 8'h00);
      check("reset_mid_flags", {Rx_VALID, Rx_PERROR, Rx_FERROR}, 3'b000);
      last_data = 8'h00;
    end
    drive_bit(d[4], bclk / 2 - 1);
    for (int i = 5; i < 8; i++) drive_bit(d[i], bclk);
    drive_bit(1'b0, bclk);
    drive_bit(1'b1, bclk);
    reset = 1'b0;
    Rx_EN = 1'b1;
    drive_bit(1'b1, bclk);
    check(use_reset ? "reset_abort_data" : "en_abort_data", Rx_DATA, last_data);
  endtask

  // Scoreboard: every result pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (Rx_VALID || Rx_PERROR || Rx_FERROR) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: got v=%b p=%b f=%b data=%h, required no pulse",
                 Rx_VALID, Rx_PERROR, Rx_FERROR, Rx_DATA);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("pulse_data", Rx_DATA, e.d);
        check("pulse_flags", {Rx_VALID, Rx_PERROR, Rx_FERROR}, {e.v, e.p, e.f});
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  vec_t vecs[6];

  initial begin
    vecs[0] = '{d: 8'h9A, par: 1'b0, stop: 1'b1, baud: 3'd7, ev: 1'b1, ep: 1'b0, ef: 1'b0};
    vecs[1] = '{d: 8'h00, par: 1'b0, stop: 1'b1, baud: 3'd6, ev: 1'b1, ep: 1'b0, ef: 1'b0};
    vecs[2] = '{d: 8'hFF, par: 1'b0, stop: 1'b1, baud: 3'd6, ev: 1'b1, ep: 1'b0, ef: 1'b0};
    vecs[3] = '{d: 8'h01, par: 1'b0, stop: 1'b1, baud: 3'd7, ev: 1'b0, ep: 1'b1, ef: 1'b0};
    vecs[4] = '{d: 8'h55, par: 1'b0, stop: 1'b0, baud: 3'd7, ev: 1'b0, ep: 1'b0, ef: 1'b1};
    vecs[5] = '{d: 8'hC3, par: 1'b1, stop: 1'b0, baud: 3'd7, ev: 1'b0, ep: 1'b1, ef: 1'b1};

    reset = 1'b1;
    RxD = 1'b1;
    Rx_EN = 1'b1;
    baud_select = 3'd7;
    last_data = 8'h00;
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("reset_data", Rx_DATA, 8'h00);
    check("reset_valid", Rx_VALID, 1'b0);
    check("reset_perror", Rx_PERROR, 1'b0);
    check("reset_ferror", Rx_FERROR, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    tick(5);

    // Table rows are sent back-to-back whenever the stop bit is good.
    for (int i = 0; i < 6; i++) begin
      expect_frame($sformatf("row%0d", i), vecs[i].d, vecs[i].ev, vecs[i].ep, vecs[i].ef,
                   vecs[i].par, vecs[i].stop, vecs[i].baud);
    end

    // Short low glitch in IDLE must not produce a frame.
    baud_select = 3'd7;
    drive_bit(1'b0, 3 * 27);
    drive_bit(1'b1, 2 * 432);
    check("glitch_data_held", Rx_DATA, last_data);
    expect_frame("after_glitch", 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd7);

    abort_frame(1'b0);
    expect_frame("after_en_abort", 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd7);

    abort_frame(1'b1);
    tick(3);
    expect_frame("after_reset_abort", 8'h9A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd7);

    tick(10);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
